seq_detector_param: RTL

Parameterised serial pattern detector, the successor to the fixed 4-bit "1101" detector FSM. It takes one qualified bit per cycle and compares it against a runtime-loadable pattern of 1..N bits. Overlapping or non-overlapping match mode is selectable. A saturating match counter feeds the lab status display and downstream control logic.

---
 rtl/seq_detector_param.sv | 86 ++++++++
 1 files changed

// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-loadable pattern of 1..N bits,
// selectable overlap mode and a saturating match counter.
module seq_detector_param #(
  parameter int unsigned N     = 8,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned LEN_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic             din,
  input  logic             cfg_load,
  input  logic [N-1:0]     pat_in,
  input  logic [LEN_W-1:0] len_in,
  input  logic             ovl_in,
  input  logic             cnt_clr,
  output logic             dout,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  // Only N-1 history bits need storing: the oldest bit leaves on the next shift
  // and the compare always looks at the freshly shifted vector.
  logic [N-2:0]     hist;
  logic [N-1:0]     hist_nx;
  logic [N-1:0]     mask_c;
  logic [N-1:0]     cfg_pat;
  logic [LEN_W-1:0] cfg_len;
  logic [LEN_W-1:0] fill;
  logic [LEN_W-1:0] fill_nx;
  logic             cfg_ovl;
  logic             len_ok_c;
  logic             match_c;

  // Next history/fill and match decision for the bit being sampled
  always_comb begin
    hist_nx  = {hist, din};
    fill_nx  = (fill == LEN_W'(N)) ? fill : fill + LEN_W'(1);
    mask_c   = '0;
    for (int i = 0; i < N; i++) begin
      mask_c[i] = (LEN_W'(i) < cfg_len);
    end
    len_ok_c = (cfg_len != '0) && (cfg_len <= LEN_W'(N));
    match_c  = len_ok_c && (fill_nx >= cfg_len) &&
               (((hist_nx ^ cfg_pat) & mask_c) == '0);
  end

  // Configuration, history and match pulse
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cfg_pat <= N'(4'b1101);
      cfg_len <= LEN_W'(4);
      cfg_ovl <= 1'b1;
      hist    <= '0;
      fill    <= '0;
      dout    <= 1'b0;
    end else if (cfg_load) begin
      cfg_pat <= pat_in;
      cfg_len <= len_in;
      cfg_ovl <= ovl_in;
      hist    <= '0;
      fill    <= '0;
      dout    <= 1'b0;
    end else if (en) begin
      hist <= hist_nx[N-2:0];
      fill <= (match_c && !cfg_ovl) ? '0 : fill_nx;
      dout <= match_c;
    end else begin
      dout <= 1'b0;
    end
  end

  // Saturating match counter; a clear coinciding with a pulse leaves one count
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      match_cnt <= '0;
    end else if (cnt_clr) begin
      match_cnt <= dout ? CNT_W'(1) : '0;
    end else if (dout && (match_cnt != '1)) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end

  assign cnt_sat = &match_cnt;

endmodule
